// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: state encoding,
// lamp encodings and default interval lengths.
package traffic_pkg;

    localparam int T_BASE_DEF  = 6;
    localparam int T_EXT_DEF   = 3;
    localparam int T_YEL_DEF   = 2;
    localparam int TIMER_W_DEF = 4;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        MG   = 3'd0,
        MY   = 3'd1,
        WALK = 3'd2,
        SG   = 3'd3,
        SGX  = 3'd4,
        SY   = 3'd5
    } state_e;

    typedef struct packed {
        logic [2:0] main_lamp;
        logic [2:0] side_lamp;
        logic       walk;
    } lamps_t;

    // Pure decode of a state: exactly one lamp per street set is lit.
    function automatic lamps_t lamps_of(state_e st);
        lamps_t l;
        l = '{main_lamp: LAMP_RED, side_lamp: LAMP_RED, walk: 1'b0};
        case (st)
            MG:      l.main_lamp = LAMP_GRN;
            MY:      l.main_lamp = LAMP_YEL;
            WALK:    l.walk      = 1'b1;
            SG, SGX: l.side_lamp = LAMP_GRN;
            SY:      l.side_lamp = LAMP_YEL;
            default: l.main_lamp = LAMP_GRN;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Down-counting interval timer advanced by the 1 Hz Tick enable; Expired is count==0.
// Start loads Interval and swallows a coincident Tick; the count saturates at zero.
module interval_timer
    import traffic_pkg::*;
#(
    parameter int TIMER_W   = TIMER_W_DEF,
    parameter int RESET_VAL = T_BASE_DEF
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Tick,
    input  logic               Start,
    input  logic [TIMER_W-1:0] Interval,
    output logic               Expired
);

    localparam logic [TIMER_W-1:0] RST_CNT = TIMER_W'(RESET_VAL);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (Start) begin
            count_d = Interval;
        end else if (Tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            count_q <= RST_CNT;
        end else begin
            count_q <= count_d;
        end
    end

    assign Expired = (count_q == '0);

    // Without a load the count may only hold or step down; it never wraps.
    a_no_wrap: assert property (@(posedge clk) disable iff (Reset)
        !Start |=> (count_q <= $past(count_q)));

endmodule

// File: rtl/traffic_light_fsm.sv
// Intersection sequencer: main/side/walk lamps driven from the state register,
// state advances one clk after the interval timer reaches zero; no backpressure.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int T_BASE  = T_BASE_DEF,
    parameter int T_EXT   = T_EXT_DEF,
    parameter int T_YEL   = T_YEL_DEF,
    parameter int TIMER_W = TIMER_W_DEF
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Sensor_Sync,
    input  logic       WR,
    output logic       WR_Reset,
    output logic [2:0] Main_Lights,
    output logic [2:0] Side_Lights,
    output logic       Walk_Lamp
);

    localparam logic [TIMER_W-1:0] IV_BASE = TIMER_W'(T_BASE);
    localparam logic [TIMER_W-1:0] IV_EXT  = TIMER_W'(T_EXT);
    localparam logic [TIMER_W-1:0] IV_YEL  = TIMER_W'(T_YEL);

    state_e             state_q;
    state_e             state_d;
    logic               start;
    logic               expired;
    logic [TIMER_W-1:0] interval;
    logic               wr_reset_q;
    logic               wr_reset_d;
    lamps_t             lamps;

    // Inputs are only consulted on the expiry cycle; every expiry reloads the
    // timer, including the MG re-arm where the state does not change.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        if (expired) begin
            start = 1'b1;
            unique case (state_q)
                MG:      state_d = (Sensor_Sync || WR) ? MY : MG;
                MY:      state_d = WR ? WALK : SG;
                WALK:    state_d = Sensor_Sync ? SG : MG;
                SG:      state_d = Sensor_Sync ? SGX : SY;
                SGX:     state_d = SY;
                SY:      state_d = MG;
                default: state_d = MG;
            endcase
        end
    end

    always_comb begin
        interval = IV_BASE;
        unique case (state_d)
            MG, SG:    interval = IV_BASE;
            MY, SY:    interval = IV_YEL;
            WALK, SGX: interval = IV_EXT;
            default:   interval = IV_BASE;
        endcase
    end

    assign wr_reset_d = (state_d == WALK) && (state_q != WALK);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= MG;
            wr_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_reset_q <= wr_reset_d;
        end
    end

    interval_timer #(
        .TIMER_W   (TIMER_W),
        .RESET_VAL (T_BASE)
    ) u_timer (
        .clk      (clk),
        .Reset    (Reset),
        .Tick     (Tick),
        .Start    (start),
        .Interval (interval),
        .Expired  (expired)
    );

    assign lamps       = lamps_of(state_q);
    assign Main_Lights = lamps.main_lamp;
    assign Side_Lights = lamps.side_lamp;
    assign Walk_Lamp   = lamps.walk;
    assign WR_Reset    = wr_reset_q;

    a_lamps_onehot: assert property (@(posedge clk) disable iff (Reset)
        $onehot(Main_Lights) && $onehot(Side_Lights));

    a_wr_reset_pulse: assert property (@(posedge clk)
        WR_Reset |=> !WR_Reset);

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: expected lamp phases and their dwell in ticks are
// queued per scenario and compared whenever the observed lamp pattern changes.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Tick;
    logic       Sensor_Sync;
    logic       WR;
    logic       WR_Reset;
    logic [2:0] Main_Lights;
    logic [2:0] Side_Lights;
    logic       Walk_Lamp;

    // {main[2:0], side[2:0], walk}
    localparam logic [6:0] P_MG   = 7'b001_100_0;
    localparam logic [6:0] P_MY   = 7'b010_100_0;
    localparam logic [6:0] P_WALK = 7'b100_100_1;
    localparam logic [6:0] P_SG   = 7'b100_001_0;
    localparam logic [6:0] P_SY   = 7'b100_010_0;

    typedef struct {
        logic [6:0] lamps;
        int         ticks;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    string      scen     = "init";
    bit         mon_en   = 1'b0;
    bit         ped_btn  = 1'b0;
    int         force_req = 0;
    int         wr_pulses = 0;
    logic [6:0] phase;
    int         ph_ticks;
    int         ph_cycles;
    logic       prev_tick;
    logic       prev_reset;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clk         (clk),
        .Reset       (Reset),
        .Tick        (Tick),
        .Sensor_Sync (Sensor_Sync),
        .WR          (WR),
        .WR_Reset    (WR_Reset),
        .Main_Lights (Main_Lights),
        .Side_Lights (Side_Lights),
        .Walk_Lamp   (Walk_Lamp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", scen, tag, got, exp);
    endtask

    task automatic push(input logic [6:0] lamps, input int ticks);
        exp_t e;
        e.lamps = lamps;
        e.ticks = ticks;
        sb.push_back(e);
    endtask

    task automatic end_phase();
        exp_t e;
        chk("phase_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("phase_lamps", phase, e.lamps);
            chk("phase_ticks", ph_ticks, e.ticks);
            chk("lamps_onehot", {$onehot(phase[6:4]), $onehot(phase[3:1])}, 2'b11);
        end
    endtask

    // Tick generator: one-cycle pulse every 10 clk, plus on-demand extra ticks.
    initial begin
        int div = 0;
        int seen = 0;
        Tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (force_req != seen) begin
                seen = force_req;
                Tick = 1'b1;
            end else if (div == 9) begin
                div  = 0;
                Tick = 1'b1;
            end else begin
                div++;
                Tick = 1'b0;
            end
        end
    end

    // External walk register: set by the pedestrian button, cleared by WR_Reset.
    initial begin
        WR = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (Reset || WR_Reset) WR = 1'b0;
            else if (ped_btn) WR = 1'b1;
        end
    end

    // Phase monitor. A tick counts toward a phase only when the posedge that
    // consumed it left the lamp pattern unchanged and Reset was low.
    initial begin
        bit         active = 1'b0;
        logic [6:0] cur;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                active = 1'b0;
            end else begin
                cur = {Main_Lights, Side_Lights, Walk_Lamp};
                if (!active) begin
                    phase = cur; ph_ticks = 0; ph_cycles = 0; active = 1'b1;
                end else if (cur != phase || prev_reset) begin
                    end_phase();
                    phase = cur; ph_ticks = 0; ph_cycles = 0;
                end else begin
                    ph_cycles++;
                    if (prev_tick) ph_ticks++;
                end
                if (WR_Reset === 1'b1) begin
                    wr_pulses++;
                    chk("wr_reset_at_walk_entry", {Walk_Lamp, ph_cycles == 0}, 2'b11);
                end
            end
            prev_tick  = Tick;
            prev_reset = Reset;
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        Reset   = 1'b1;
        ped_btn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_main", Main_Lights, 3'b001);
        chk("rst_side", Side_Lights, 3'b100);
        chk("rst_walk", Walk_Lamp, 1'b0);
        chk("rst_wr_reset", WR_Reset, 1'b0);
        @(posedge clk);
        #1;
        Reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (Tick) seen++;
        end
        chk("wait_ticks", seen, n);
    endtask

    task automatic wait_lamps(input logic [6:0] pat);
        bit found = 1'b0;
        int cyc   = 0;
        while (!found && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if ({Main_Lights, Side_Lights, Walk_Lamp} == pat) found = 1'b1;
        end
        chk("wait_lamps", found, 1'b1);
    endtask

    task automatic drain();
        int cyc = 0;
        while (sb.size() > 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int w0;
        Reset       = 1'b1;
        Sensor_Sync = 1'b0;

        scen = "idle";
        do_reset();
        w0 = wr_pulses;
        wait_ticks(40);
        chk("main_green", Main_Lights, 3'b001);
        chk("side_red", Side_Lights, 3'b100);
        chk("walk_off", Walk_Lamp, 1'b0);
        chk("wr_reset_count", wr_pulses - w0, 0);
        drain();

        scen = "side_cycle";
        Sensor_Sync = 1'b1;
        do_reset();
        push(P_MG, 6); push(P_MY, 2); push(P_SG, 9); push(P_SY, 2);
        drain();
        chk("back_to_mg", {Main_Lights, Side_Lights, Walk_Lamp}, P_MG);

        scen = "walk";
        Sensor_Sync = 1'b0;
        do_reset();
        w0 = wr_pulses;
        ped_btn = 1'b1;
        push(P_MG, 6); push(P_MY, 2); push(P_WALK, 3);
        wait_ticks(3);
        ped_btn = 1'b0;
        drain();
        chk("back_to_mg", {Main_Lights, Side_Lights, Walk_Lamp}, P_MG);
        chk("wr_reset_count", wr_pulses - w0, 1);

        scen = "walk_then_side";
        Sensor_Sync = 1'b1;
        do_reset();
        w0 = wr_pulses;
        ped_btn = 1'b1;
        push(P_MG, 6); push(P_MY, 2); push(P_WALK, 3); push(P_SG, 9); push(P_SY, 2);
        wait_ticks(1);
        ped_btn = 1'b0;
        drain();
        chk("wr_reset_count", wr_pulses - w0, 1);

        scen = "mid_reset";
        Sensor_Sync = 1'b1;
        do_reset();
        push(P_MG, 6); push(P_MY, 2); push(P_SG, 3); push(P_MG, 6); push(P_MY, 2);
        wait_lamps(P_SG);
        wait_ticks(3);
        @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        @(negedge clk);
        chk("post_reset_main", Main_Lights, 3'b001);
        chk("post_reset_side", Side_Lights, 3'b100);
        drain();

        scen = "tick_on_start";
        Sensor_Sync = 1'b1;
        do_reset();
        push(P_MG, 6); push(P_MY, 2); push(P_SG, 9); push(P_SY, 2);
        wait_lamps(P_MY);
        wait_ticks(2);
        force_req++;
        drain();

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected normal completion");
        $fatal(1);
    end

endmodule
